// File: rtl/sdp_pkg.sv
// Shared constants for the seven-segment scan driver.
//   SEG_W    : width of the seg bus (a..g plus dp)
//   SEG_OFF  : all segments dark (active-low)
//   HEX_SEG  : hex nibble -> active-low segments, bit order g..a
package sdp_pkg;

  localparam int unsigned SEG_W = 8;

  localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,  // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,  // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,  // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E   // C d E F
  };

endpackage

// File: rtl/sdp_scan_driver_if.sv
// Host/pin bundle for sdp_scan_driver.
//   master : display register logic (drives load/data/brightness, sees status and pins)
//   slave  : the scan driver itself
// Signals: load, digit_data[4*DIGITS], dp_data, blank_mask, brightness,
//          pending, frame_done, seg[8] (active-low), an[DIGITS] (active-low).
interface sdp_scan_driver_if
  import sdp_pkg::*;
#(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned DUTY_BITS = 4
);

  logic                  load;
  logic [4*DIGITS-1:0]   digit_data;
  logic [DIGITS-1:0]     dp_data;
  logic [DIGITS-1:0]     blank_mask;
  logic [DUTY_BITS-1:0]  brightness;
  logic                  pending;
  logic                  frame_done;
  logic [SEG_W-1:0]      seg;
  logic [DIGITS-1:0]     an;

  modport master (
    output load, digit_data, dp_data, blank_mask, brightness,
    input  pending, frame_done, seg, an
  );

  modport slave (
    input  load, digit_data, dp_data, blank_mask, brightness,
    output pending, frame_done, seg, an
  );

endinterface

// File: rtl/sdp_hexdec.sv
// Combinational hex nibble to seven-segment decoder.
//   nibble_i : 4-bit hex value
//   seg_n_o  : active-low segments, [0]=a .. [6]=g
module sdp_hexdec
  import sdp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/sdp_scan_driver.sv
// Time-multiplexed common-anode seven-segment scan driver.
// Digit data is loaded into a shadow buffer and promoted to the displayed
// (active) buffer only at a frame boundary, so a frame never mixes old and
// new content. Brightness is a PWM window at the start of every digit slot.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sdp_scan_driver_if.slave (load/data in, pending/frame_done/seg/an out)
module sdp_scan_driver
  import sdp_pkg::*;
#(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned CLK_DIV   = 100000,
  parameter int unsigned DUTY_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  sdp_scan_driver_if.slave bus
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned DW = 4 * DIGITS;
  // Wide enough for (2**DUTY_BITS) * CLK_DIV without overflow.
  localparam int unsigned TW = $clog2(CLK_DIV + 1) + DUTY_BITS + 1;

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     sh_digit_q, sh_digit_d, act_digit_q, act_digit_d;
  logic [DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0] sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic              pending_q, pending_d;
  logic              frame_done_q, frame_done_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic              tick;
  logic              wrap;
  logic [TW-1:0]     thr;
  logic              lit;
  logic [3:0]        cur_nib;
  logic [6:0]        cur_seg_n;

  sdp_hexdec u_hexdec (
    .nibble_i (cur_nib),
    .seg_n_o  (cur_seg_n)
  );

  always_comb begin
    tick = (presc_q == PW'(CLK_DIV - 1));
    wrap = tick && (idx_q == IW'(DIGITS - 1));

    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end
    frame_done_d = wrap;

    sh_digit_d  = sh_digit_q;
    sh_dp_d     = sh_dp_q;
    sh_blank_d  = sh_blank_q;
    act_digit_d = act_digit_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    pending_d   = pending_q;

    // Promotion uses the shadow as it was before this cycle; a load in the
    // same cycle lands in the shadow and stays pending for the next frame.
    if (wrap && pending_q) begin
      act_digit_d = sh_digit_q;
      act_dp_d    = sh_dp_q;
      act_blank_d = sh_blank_q;
      pending_d   = 1'b0;
    end
    if (bus.load) begin
      sh_digit_d = bus.digit_data;
      sh_dp_d    = bus.dp_data;
      sh_blank_d = bus.blank_mask;
      pending_d  = 1'b1;
    end

    // All-ones brightness yields thr == CLK_DIV, i.e. lit for the whole slot.
    thr = ((TW'(bus.brightness) + TW'(1)) * TW'(CLK_DIV)) >> DUTY_BITS;
    lit = (TW'(presc_q) < thr) && !act_blank_q[idx_q];

    cur_nib = act_digit_q[{idx_q, 2'b00} +: 4];
    an_d    = lit ? ~(DIGITS'(1) << idx_q) : '1;
    seg_d   = lit ? {~act_dp_q[idx_q], cur_seg_n} : SEG_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      sh_digit_q   <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '1;
      act_digit_q  <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= '1;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      sh_digit_q   <= sh_digit_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      act_digit_q  <= act_digit_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;
  assign bus.seg        = seg_q;
  assign bus.an         = an_q;

endmodule

// File: tb/tb_sdp_scan_driver.sv
// Scoreboard bench for sdp_scan_driver (DIGITS=4, CLK_DIV=16, DUTY_BITS=2).
// The stimulus thread pushes one record per lit digit slot it expects
// (anode, segments, lit length); the monitor splits the output stream into
// runs of constant {an,seg} and pops one record for every run with a lit anode.
module tb_sdp_scan_driver;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned CLK_DIV   = 16;
  localparam int unsigned DUTY_BITS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sdp_scan_driver_if #(.DIGITS(DIGITS), .DUTY_BITS(DUTY_BITS)) bus ();

  sdp_scan_driver #(
    .DIGITS    (DIGITS),
    .CLK_DIV   (CLK_DIV),
    .DUTY_BITS (DUTY_BITS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Bench-side view of the two buffers.
  logic [15:0] sh_d_m, act_d_m;
  logic [3:0]  sh_dp_m, act_dp_m, sh_bl_m, act_bl_m;
  bit          pend_m;
  logic [1:0]  bright_m;

  task automatic model_reset();
    sh_d_m = '0; act_d_m = '0; sh_dp_m = '0; act_dp_m = '0;
    sh_bl_m = '1; act_bl_m = '1; pend_m = 1'b0;
  endtask

  task automatic push_frame();
    exp_t e;
    int   thr;
    thr = ((int'(bright_m) + 1) * CLK_DIV) >> DUTY_BITS;
    for (int i = 0; i < DIGITS; i++) begin
      if (!act_bl_m[i]) begin
        e.an  = ~(4'(1) << i);
        e.seg = {~act_dp_m[i], hexseg(act_d_m[i*4 +: 4])};
        e.len = thr;
        exp_q.push_back(e);
      end
    end
  endtask

  // ---------------- monitor ----------------
  int         cyc     = 0;
  int         last_fd = -1;
  logic [3:0] run_an  = 4'hF;
  logic [7:0] run_seg = 8'hFF;
  int         run_len = 0;
  exp_t       mon_e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      // A slot cut short by reset is dropped; the stimulus flushes the queue.
      run_an  = 4'hF;
      run_seg = 8'hFF;
      run_len = 0;
      last_fd = -1;
    end else begin
      if (bus.frame_done) begin
        if (last_fd >= 0) check("frame_done_period", 32'(cyc - last_fd), 64);
        last_fd = cyc;
      end
      if (bus.an !== run_an || bus.seg !== run_seg) begin
        if (run_an !== 4'hF) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_slot: got an=%h seg=%h len=%0d, required no lit slot",
                     run_an, run_seg, run_len);
          end else begin
            mon_e = exp_q.pop_front();
            check("slot_an", 32'(run_an), 32'(mon_e.an));
            check("slot_seg", 32'(run_seg), 32'(mon_e.seg));
            check("slot_len", 32'(run_len), 32'(mon_e.len));
          end
        end
        run_an  = bus.an;
        run_seg = bus.seg;
        run_len = 1;
      end else begin
        run_len++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic scramble();
    bus.digit_data = 16'($urandom);
    bus.dp_data    = 4'($urandom);
    bus.blank_mask = 4'($urandom);
  endtask

  task automatic wait_fd(input bit chk_dark);
    bit seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (chk_dark) begin
        check("dark_an", 32'(bus.an), 32'hF);
        check("dark_seg", 32'(bus.seg), 32'hFF);
      end
      if (bus.frame_done) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL frame_done_timeout: got no pulse in 100 cycles, required one");
    end
  endtask

  // Returns at the negedge where frame_done is high; the new frame starts now.
  task automatic next_frame(input logic [1:0] b, input bit chk_dark);
    wait_fd(chk_dark);
    bus.brightness = b;
    bright_m       = b;
    if (pend_m) begin
      act_d_m = sh_d_m; act_dp_m = sh_dp_m; act_bl_m = sh_bl_m;
      pend_m  = 1'b0;
    end
    check("pending_after_wrap", 32'(bus.pending), 32'(pend_m));
    push_frame();
  endtask

  task automatic load_now(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    bus.digit_data = d;
    bus.dp_data    = dp;
    bus.blank_mask = bl;
    bus.load       = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    scramble();
    sh_d_m = d; sh_dp_m = dp; sh_bl_m = bl; pend_m = 1'b1;
    check("pending_after_load", 32'(bus.pending), 1);
  endtask

  // Load captured on the wrap edge itself; elapsed = cycles since frame_done.
  task automatic load_at_wrap(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                              input int elapsed);
    repeat (63 - elapsed) @(negedge clk);
    bus.digit_data = d;
    bus.dp_data    = dp;
    bus.blank_mask = bl;
    bus.load       = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    scramble();
    check("wrap_aligned_load", 32'(bus.frame_done), 1);
    if (pend_m) begin
      act_d_m = sh_d_m; act_dp_m = sh_dp_m; act_bl_m = sh_bl_m;
    end
    sh_d_m = d; sh_dp_m = dp; sh_bl_m = bl; pend_m = 1'b1;
    check("pending_across_wrap", 32'(bus.pending), 1);
    push_frame();
  endtask

  initial begin
    bus.load       = 1'b0;
    bus.digit_data = '0;
    bus.dp_data    = '0;
    bus.blank_mask = '0;
    bus.brightness = 2'd3;
    bright_m       = 2'd3;
    model_reset();

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(bus.an), 32'hF);
    check("rst_seg", 32'(bus.seg), 32'hFF);
    check("rst_pending", 32'(bus.pending), 0);
    check("rst_frame_done", 32'(bus.frame_done), 0);
    rst_n = 1'b1;

    // 1: idle, dark, frame_done every 64 cycles
    repeat (200) begin
      @(negedge clk);
      check("idle_an", 32'(bus.an), 32'hF);
      check("idle_seg", 32'(bus.seg), 32'hFF);
    end
    check("idle_pending", 32'(bus.pending), 0);

    // 2: basic load and promotion, full brightness
    next_frame(2'd3, 1'b1);
    load_now(16'h3210, 4'b0100, 4'b0000);
    next_frame(2'd3, 1'b1);
    next_frame(2'd3, 1'b0);

    // 3: load coincident with wrap
    load_now(16'h1111, 4'b0000, 4'b0000);
    load_at_wrap(16'h2222, 4'b0000, 4'b0000, 1);
    next_frame(2'd3, 1'b0);

    // 4: blanking digits 1 and 3
    load_now(16'hA5C8, 4'b0001, 4'b1010);
    next_frame(2'd3, 1'b0);
    next_frame(2'd3, 1'b0);

    // 5: PWM brightness
    load_now(16'h3210, 4'b0100, 4'b0000);
    next_frame(2'd0, 1'b0);
    next_frame(2'd0, 1'b0);
    next_frame(2'd1, 1'b0);

    // 6: asynchronous reset with digit 2 lit
    next_frame(2'd3, 1'b0);
    repeat (40) @(negedge clk);
    check("mid_slot_an", 32'(bus.an), 32'hB);
    check("mid_slot_seg", 32'(bus.seg), 32'h24);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an", 32'(bus.an), 32'hF);
    check("async_rst_seg", 32'(bus.seg), 32'hFF);
    check("async_rst_pending", 32'(bus.pending), 0);
    @(negedge clk);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    next_frame(2'd3, 1'b1);
    load_now(16'hC0DE, 4'b1000, 4'b0000);
    next_frame(2'd3, 1'b1);
    load_now(16'h0000, 4'b0000, 4'b1111);
    next_frame(2'd3, 1'b0);
    repeat (20) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdp_scan_driver.md
Name: sdp_scan_driver

Overview:
Parametrised time-multiplexed seven-segment scan driver for DIGITS common-anode digits with active-low anodes and segments.
- Replaces the fixed divider / 3-bit counter / ROM chain with loadable, double-buffered digit data.
- Adds per-digit blanking, decimal points and PWM brightness.
- Provides a frame-done strobe.
- Sits between the system-level display register logic and the board seg/an pins.

Parameters:
DIGITS, 8, number of multiplexed digits (2..8); anode width.
CLK_DIV, 100000, clk cycles per digit slot (must be >= 2**DUTY_BITS).
DUTY_BITS, 4, brightness resolution in bits.

Ports:
clk  in  1  system clock; everything is in this domain.
rst_n  in  1  asynchronous, active-low reset.
load  in  1  single-cycle strobe; captures digit_data, dp_data and blank_mask into the shadow buffer.
digit_data  in  4*DIGITS  hex nibble per digit; digit i is [4i+3:4i].
dp_data  in  DIGITS  decimal point per digit; 1 = lit.
blank_mask  in  DIGITS  1 = digit dark.
brightness  in  DUTY_BITS  on-time level; all-ones = 100 %.
pending  out  1  shadow holds data not yet promoted to the active buffer.
frame_done  out  1  one-cycle pulse when digit DIGITS-1 slot ends.
seg  out  8  active-low segments: [0]=a … [6]=g, [7]=dp.
an  out  DIGITS  active-low anode enables; at most one bit low at any time.

Behaviour:
- Reset (async on rst_n low):
  - prescaler=0, idx=0, pending=0, frame_done=0.
  - Shadow and active buffers: digits=0, dp=0, blank=all 1.
  - seg=8'hFF, an=all 1.
  - The display stays dark until the first load has been promoted.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick = (prescaler==CLK_DIV-1).
- Digit index:
  - On tick, idx increments; wraps DIGITS-1 -> 0.
  - wrap = tick && idx==DIGITS-1.
  - frame_done is registered high for exactly the cycle after wrap.
- Double buffer:
  - load=1: shadow <= inputs, pending <= 1.
  - On wrap with pending=1: active <= shadow (value held before this cycle), pending <= 0.
  - load coincident with wrap: active gets the old shadow, shadow gets the new data, pending stays 1; the new data is promoted on the next wrap.
  - load on every cycle is legal; the last captured data wins.
- Brightness:
  - on = (prescaler < thr), where thr = ((brightness+1)*CLK_DIV) >> DUTY_BITS, computed at CLK_DIV-sized width with no overflow.
  - brightness = 2**DUTY_BITS-1 gives thr=CLK_DIV, i.e. always on.
  - thr ≥ 1 for all legal parameter values.
- Output register (one-cycle latency from idx/prescaler):
  - an <= ~(1<<idx) when on && !blank[idx]; otherwise all 1.
  - seg <= {~dp[idx], decode(digit[idx])} when the anode is enabled; otherwise 8'hFF.
  - seg and an change in the same cycle, so no ghosting.
- Decode table (bits g..a, active low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Reset mid-frame returns all state to reset values immediately; anodes go dark asynchronously.

Decomposition:
- Package sdp_pkg holds:
  - SEG_W=8.
  - Active-low SEG_OFF constant.
  - The 16-entry hex-to-segment constant array.
- One combinational sub-module, sdp_hexdec (4-bit in, 7-bit active-low out), instantiated once on the muxed nibble.

Test Plan (DIGITS=4, CLK_DIV=16, DUTY_BITS=2 unless stated):
1. Reset then idle 200 cycles -> an=4'hF and seg=8'hFF throughout; pending=0; frame_done pulses every 64 cycles.
2. load digit_data=16'h3210, dp=4'b0100, blank=0, brightness=3 -> pending=1 until the next wrap; then each slot is 16 cycles in the order an=E,D,B,7 with seg=C0,F9,24(dp low → 8'h24),B0; pending=0.
3. load coincident with the wrap cycle (first 16'h1111, then 16'h2222) -> the next frame shows 1111; the following frame shows 2222; pending stays 1 across the first wrap.
4. blank_mask=4'b1010 -> an is never low for digits 1 and 3 during their slots; seg=FF in those slots.
5. brightness=0 -> each anode is low for exactly 4 of 16 cycles (prescaler 0..3, visible one cycle later); brightness=1 -> 8 cycles.
6. Assert rst_n low mid-slot with digit 2 active -> an=F and seg=FF in the same cycle; after release the display stays dark until a new load is promoted.
